// File: rtl/mm_pkg.sv
// Shared types and helpers for the Mastermind scorer: FSM state encoding,
// default code geometry, peg extraction and the histogram min used when summing.
package mm_pkg;

  localparam int unsigned NumPegsDef = 5;
  localparam int unsigned ColorWDef  = 3;
  localparam int unsigned MaxCodeW   = 128;
  localparam int unsigned MaxColorW  = 8;
  localparam int unsigned MaxCntW    = 8;

  typedef enum logic [2:0] {
    StNoSecret,
    StReady,
    StScan,
    StSum,
    StDone,
    StWon,
    StLost
  } mm_state_e;

  // Code is zero-extended to MaxCodeW by the caller; result is masked to cw bits.
  function automatic logic [MaxColorW-1:0] peg(input logic [MaxCodeW-1:0] code,
                                               input int unsigned         i,
                                               input int unsigned         cw);
    logic [MaxColorW-1:0] mask;
    mask = MaxColorW'((1 << cw) - 1);
    return MaxColorW'(code >> (i * cw)) & mask;
  endfunction

  function automatic logic [MaxCntW-1:0] min_cnt(input logic [MaxCntW-1:0] a,
                                                 input logic [MaxCntW-1:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/mm_peg_hist.sv
// Per-colour occurrence counter file: synchronous clear, increment at one index,
// combinational read at another index.
module mm_peg_hist
  import mm_pkg::*;
#(
  parameter int unsigned NUM_COLORS = 8,
  parameter int unsigned IDX_W      = ColorWDef,
  parameter int unsigned CNT_W      = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  input  logic [IDX_W-1:0] inc_idx,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [CNT_W-1:0] rd_data
);

  logic [CNT_W-1:0] cnt_q [NUM_COLORS];

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      for (int unsigned i = 0; i < NUM_COLORS; i++) cnt_q[i] <= '0;
    end else if (inc) begin
      for (int unsigned i = 0; i < NUM_COLORS; i++) begin
        if (IDX_W'(i) == inc_idx) cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < NUM_COLORS; i++) begin
      if (IDX_W'(i) == rd_idx) rd_data = cnt_q[i];
    end
  end

endmodule

// File: rtl/mastermind_scorer.sv
// Sequential Mastermind scorer: exact-match scan then colour-histogram min-sum.
// Optional turn limit enabled by defining SCORER_TURN_LIMIT_EN.
module mastermind_scorer
  import mm_pkg::*;
#(
  parameter int unsigned NUM_PEGS   = NumPegsDef,
  parameter int unsigned NUM_COLORS = 8,
  parameter int unsigned COLOR_W    = ColorWDef,
  parameter int unsigned MAX_TURNS  = 10,
  localparam int unsigned CNT_W     = $clog2(NUM_PEGS + 1),
  localparam int unsigned TURN_W    = $clog2(MAX_TURNS + 1),
  localparam int unsigned CODE_W    = NUM_PEGS * COLOR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              secret_load,
  input  logic [CODE_W-1:0] secret_in,
  output logic              secret_err,
  input  logic              guess_valid,
  output logic              guess_ready,
  input  logic [CODE_W-1:0] guess_in,
  output logic              score_valid,
  output logic [CNT_W-1:0]  cor_p,
  output logic [CNT_W-1:0]  cor_c,
  output logic              win,
  output logic              busy,
  output logic [TURN_W-1:0] turn,
  output logic              game_over
);

  localparam int unsigned P_W   = $clog2(NUM_PEGS);
  localparam int unsigned CMP_W = COLOR_W + 1;

  mm_state_e         state_q;
  logic [CODE_W-1:0] secret_q, guess_q;
  logic [P_W-1:0]    p_q;
  logic [COLOR_W-1:0] c_q;
  logic [CNT_W-1:0]  exact_q, colour_q;
  logic [CNT_W-1:0]  cor_p_q, cor_c_q;
  logic              win_q, score_valid_q, secret_err_q;

  logic [COLOR_W-1:0] s_peg, g_peg;
  logic [CNT_W-1:0]   hs_cnt, hg_cnt, sum_add;
  logic               match, g_legal, secret_bad, accept, win_next, load_ok;

  assign s_peg    = COLOR_W'(peg(MaxCodeW'(secret_q), 32'(p_q), COLOR_W));
  assign g_peg    = COLOR_W'(peg(MaxCodeW'(guess_q), 32'(p_q), COLOR_W));
  assign match    = (s_peg == g_peg);
  assign g_legal  = CMP_W'(g_peg) < CMP_W'(NUM_COLORS);
  assign sum_add  = CNT_W'(min_cnt(MaxCntW'(hs_cnt), MaxCntW'(hg_cnt)));
  assign load_ok  = secret_load && !secret_bad;
  assign accept   = (state_q == StReady) && guess_valid && !secret_load;
  assign win_next = (exact_q == CNT_W'(NUM_PEGS));

  always_comb begin
    secret_bad = 1'b0;
    for (int unsigned i = 0; i < NUM_PEGS; i++) begin
      if (CMP_W'(peg(MaxCodeW'(secret_in), i, COLOR_W)) >= CMP_W'(NUM_COLORS)) secret_bad = 1'b1;
    end
  end

  // Secret pegs are always legal, so only the guess side needs the colour check.
  mm_peg_hist #(
    .NUM_COLORS (NUM_COLORS),
    .IDX_W      (COLOR_W),
    .CNT_W      (CNT_W)
  ) u_hist_s (
    .clk     (clk),
    .reset   (reset),
    .clr     (accept),
    .inc     ((state_q == StScan) && !match),
    .inc_idx (s_peg),
    .rd_idx  (c_q),
    .rd_data (hs_cnt)
  );

  mm_peg_hist #(
    .NUM_COLORS (NUM_COLORS),
    .IDX_W      (COLOR_W),
    .CNT_W      (CNT_W)
  ) u_hist_g (
    .clk     (clk),
    .reset   (reset),
    .clr     (accept),
    .inc     ((state_q == StScan) && !match && g_legal),
    .inc_idx (g_peg),
    .rd_idx  (c_q),
    .rd_data (hg_cnt)
  );

`ifdef SCORER_TURN_LIMIT_EN
  logic [TURN_W-1:0] turn_q, turn_inc;
  logic              game_over_q;
  assign turn_inc  = (turn_q == TURN_W'(MAX_TURNS)) ? turn_q : turn_q + 1'b1;
  assign turn      = turn_q;
  assign game_over = game_over_q;
`else
  assign turn      = '0;
  assign game_over = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StNoSecret;
      secret_q      <= '0;
      guess_q       <= '0;
      p_q           <= '0;
      c_q           <= '0;
      exact_q       <= '0;
      colour_q      <= '0;
      cor_p_q       <= '0;
      cor_c_q       <= '0;
      win_q         <= 1'b0;
      score_valid_q <= 1'b0;
      secret_err_q  <= 1'b0;
`ifdef SCORER_TURN_LIMIT_EN
      turn_q        <= '0;
      game_over_q   <= 1'b0;
`endif
    end else begin
      score_valid_q <= 1'b0;
      secret_err_q  <= secret_load && secret_bad;
      if (load_ok) begin
        secret_q <= secret_in;
        cor_p_q  <= '0;
        cor_c_q  <= '0;
        win_q    <= 1'b0;
        state_q  <= StReady;
`ifdef SCORER_TURN_LIMIT_EN
        turn_q      <= '0;
        game_over_q <= 1'b0;
`endif
      end else begin
        // A rejected load leaves scoring running undisturbed.
        unique case (state_q)
          StReady: begin
            if (accept) begin
              guess_q  <= guess_in;
              exact_q  <= '0;
              colour_q <= '0;
              p_q      <= '0;
              state_q  <= StScan;
            end
          end
          StScan: begin
            if (match) exact_q <= exact_q + 1'b1;
            if (p_q == P_W'(NUM_PEGS - 1)) begin
              c_q     <= '0;
              state_q <= StSum;
            end else begin
              p_q <= p_q + 1'b1;
            end
          end
          StSum: begin
            colour_q <= colour_q + sum_add;
            if (c_q == COLOR_W'(NUM_COLORS - 1)) state_q <= StDone;
            else c_q <= c_q + 1'b1;
          end
          StDone: begin
            cor_p_q       <= exact_q;
            cor_c_q       <= colour_q;
            win_q         <= win_next;
            score_valid_q <= 1'b1;
`ifdef SCORER_TURN_LIMIT_EN
            turn_q <= turn_inc;
`endif
            if (win_next) state_q <= StWon;
`ifdef SCORER_TURN_LIMIT_EN
            else if (turn_inc == TURN_W'(MAX_TURNS)) begin
              game_over_q <= 1'b1;
              state_q     <= StLost;
            end
`endif
            else state_q <= StReady;
          end
          default: ;
        endcase
      end
    end
  end

  assign guess_ready = (state_q == StReady);
  assign busy        = (state_q == StScan) || (state_q == StSum) || (state_q == StDone);
  assign score_valid = score_valid_q;
  assign secret_err  = secret_err_q;
  assign cor_p       = cor_p_q;
  assign cor_c       = cor_c_q;
  assign win         = win_q;

endmodule

// File: tb/tb_mastermind_scorer.sv
// Directed bench: instance a uses default geometry, instance b uses NUM_COLORS=6, MAX_TURNS=2.
module tb_mastermind_scorer;

`ifdef SCORER_TURN_LIMIT_EN
  localparam bit TurnLimit = 1'b1;
`else
  localparam bit TurnLimit = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic        a_load, a_err, a_gv, a_gr, a_sv, a_win, a_busy, a_go;
  logic [14:0] a_sin, a_gin;
  logic [2:0]  a_cp, a_cc;
  logic [3:0]  a_turn;

  logic        b_load, b_err, b_gv, b_gr, b_sv, b_win, b_busy, b_go;
  logic [14:0] b_sin, b_gin;
  logic [2:0]  b_cp, b_cc;
  logic [1:0]  b_turn;

  int checks = 0;
  int errors = 0;

  mastermind_scorer u_dut_a (
    .clk(clk), .reset(reset), .secret_load(a_load), .secret_in(a_sin), .secret_err(a_err),
    .guess_valid(a_gv), .guess_ready(a_gr), .guess_in(a_gin), .score_valid(a_sv),
    .cor_p(a_cp), .cor_c(a_cc), .win(a_win), .busy(a_busy), .turn(a_turn), .game_over(a_go)
  );

  mastermind_scorer #(.NUM_COLORS(6), .MAX_TURNS(2)) u_dut_b (
    .clk(clk), .reset(reset), .secret_load(b_load), .secret_in(b_sin), .secret_err(b_err),
    .guess_valid(b_gv), .guess_ready(b_gr), .guess_in(b_gin), .score_valid(b_sv),
    .cor_p(b_cp), .cor_c(b_cc), .win(b_win), .busy(b_busy), .turn(b_turn), .game_over(b_go)
  );

  function automatic logic [14:0] code(input int p0, input int p1, input int p2,
                                       input int p3, input int p4);
    return {3'(p4), 3'(p3), 3'(p2), 3'(p1), 3'(p0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_a(input logic [14:0] s);
    a_sin = s; a_load = 1'b1; tick(); a_load = 1'b0;
  endtask

  task automatic load_b(input logic [14:0] s);
    b_sin = s; b_load = 1'b1; tick(); b_load = 1'b0;
  endtask

  // lat = cycles from acceptance edge to score_valid, -1 on timeout
  task automatic guess_a(input logic [14:0] g, output int lat);
    for (int n = 0; n < 50 && !a_gr; n++) tick();
    a_gin = g; a_gv = 1'b1; tick(); a_gv = 1'b0;
    lat = -1;
    for (int i = 1; i <= 50; i++) begin
      tick();
      if (a_sv) begin lat = i; break; end
    end
  endtask

  task automatic guess_b(input logic [14:0] g, output int lat);
    for (int n = 0; n < 50 && !b_gr; n++) tick();
    b_gin = g; b_gv = 1'b1; tick(); b_gv = 1'b0;
    lat = -1;
    for (int i = 1; i <= 50; i++) begin
      tick();
      if (b_sv) begin lat = i; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    a_load = 0; a_gv = 0; a_sin = '0; a_gin = '0;
    b_load = 0; b_gv = 0; b_sin = '0; b_gin = '0;
    repeat (3) tick();
    checks++;
    if ({a_gr, a_busy, a_sv, a_win, a_err, a_go, a_cp, a_cc, a_turn} !== 19'd0) begin
      errors++; $display("FAIL reset_outputs_a: got %h want 0",
                         {a_gr, a_busy, a_sv, a_win, a_err, a_go, a_cp, a_cc, a_turn});
    end
    checks++;
    if ({b_gr, b_busy, b_sv, b_win, b_err, b_go, b_cp, b_cc, b_turn} !== 17'd0) begin
      errors++; $display("FAIL reset_outputs_b: got %h want 0",
                         {b_gr, b_busy, b_sv, b_win, b_err, b_go, b_cp, b_cc, b_turn});
    end
    reset = 1'b0;
    a_gv = 1'b1;
    repeat (3) tick();
    checks++;
    if ({a_gr, a_busy} !== 2'b00) begin
      errors++; $display("FAIL no_secret_ignores_guess: got %b want 00", {a_gr, a_busy});
    end
    a_gv = 1'b0;
  endtask

  task automatic test_latency();
    int lat;
    load_a(code(0, 0, 0, 0, 2));
    checks++;
    if (a_gr !== 1'b1) begin errors++; $display("FAIL ready_after_load: got %b want 1", a_gr); end
    guess_a(code(0, 0, 1, 2, 0), lat);
    checks++;
    if (lat !== 14) begin errors++; $display("FAIL latency: got %0d want 14", lat); end
    checks++;
    if ({a_cp, a_cc, a_win} !== {3'd2, 3'd2, 1'b0}) begin
      errors++; $display("FAIL score_22: got p=%0d c=%0d w=%b want p=2 c=2 w=0", a_cp, a_cc, a_win);
    end
    checks++;
    if ({a_gr, a_busy} !== 2'b10) begin
      errors++; $display("FAIL ready_after_score: got %b want 10", {a_gr, a_busy});
    end
    tick();
    checks++;
    if (a_sv !== 1'b0) begin errors++; $display("FAIL score_pulse_width: got %b want 0", a_sv); end
  endtask

  task automatic test_win();
    int lat;
    load_a(code(3, 1, 4, 1, 5));
    guess_a(code(3, 1, 4, 1, 5), lat);
    checks++;
    if ({a_cp, a_cc, a_win} !== {3'd5, 3'd0, 1'b1}) begin
      errors++; $display("FAIL win_score: got p=%0d c=%0d w=%b want p=5 c=0 w=1", a_cp, a_cc, a_win);
    end
    a_gv = 1'b1; a_gin = code(0, 0, 0, 0, 0);
    repeat (3) tick();
    checks++;
    if ({a_gr, a_busy, a_win} !== 3'b001) begin
      errors++; $display("FAIL won_blocks_guess: got %b want 001", {a_gr, a_busy, a_win});
    end
    a_gv = 1'b0;
    load_a(code(3, 1, 4, 1, 5));
    checks++;
    if ({a_gr, a_win, a_cp, a_cc} !== 8'b1000_0000) begin
      errors++; $display("FAIL reload_after_won: got %b want 10000000", {a_gr, a_win, a_cp, a_cc});
    end
  endtask

  task automatic test_abort();
    int lat, seen;
    guess_a(code(1, 3, 4, 5, 7), lat);
    checks++;
    if ({a_cp, a_cc} !== {3'd1, 3'd3}) begin
      errors++; $display("FAIL score_13: got p=%0d c=%0d want p=1 c=3", a_cp, a_cc);
    end
    seen = 0;
    a_gin = code(3, 1, 4, 1, 5); a_gv = 1'b1; tick(); a_gv = 1'b0;
    checks++;
    if (a_busy !== 1'b1) begin errors++; $display("FAIL busy_in_scan: got %b want 1", a_busy); end
    repeat (4) begin tick(); if (a_sv) seen++; end
    a_sin = code(2, 2, 2, 2, 2); a_load = 1'b1; tick(); a_load = 1'b0;
    checks++;
    if ({a_gr, a_busy, a_cp, a_cc} !== 8'b1000_0000) begin
      errors++; $display("FAIL abort_state: got %b want 10000000", {a_gr, a_busy, a_cp, a_cc});
    end
    repeat (20) begin tick(); if (a_sv) seen++; end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL abort_no_score: got %0d want 0", seen); end
  endtask

  task automatic test_back_to_back();
    int pulses, bad, lat;
    load_a(code(3, 1, 4, 1, 5));
    pulses = 0; bad = 0;
    a_gin = code(1, 3, 4, 5, 7); a_gv = 1'b1;
    for (int i = 1; i <= 46; i++) begin
      tick();
      if (a_sv) begin
        pulses++;
        if (a_cp !== 3'd1 || a_cc !== 3'd3) bad++;
      end
    end
    a_gv = 1'b0;
    checks++;
    if (pulses !== 3) begin errors++; $display("FAIL b2b_pulses: got %0d want 3", pulses); end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL b2b_scores: got %0d bad want 0", bad); end
    lat = -1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (a_sv) begin lat = i; break; end
    end
    checks++;
    if (lat !== 14) begin errors++; $display("FAIL b2b_last_latency: got %0d want 14", lat); end
  endtask

  task automatic test_secret_err();
    int lat;
    load_b(code(1, 2, 3, 4, 5));
    checks++;
    if ({b_err, b_gr} !== 2'b01) begin
      errors++; $display("FAIL legal_load_b: got %b want 01", {b_err, b_gr});
    end
    b_sin = code(0, 7, 0, 0, 0); b_load = 1'b1; tick(); b_load = 1'b0;
    checks++;
    if ({b_err, b_gr} !== 2'b11) begin
      errors++; $display("FAIL err_pulse_7: got %b want 11", {b_err, b_gr});
    end
    tick();
    checks++;
    if (b_err !== 1'b0) begin errors++; $display("FAIL err_pulse_width: got %b want 0", b_err); end
    b_sin = code(6, 0, 0, 0, 0); b_load = 1'b1; tick(); b_load = 1'b0;
    checks++;
    if (b_err !== 1'b1) begin errors++; $display("FAIL err_pulse_6: got %b want 1", b_err); end
    guess_b(code(1, 2, 3, 4, 7), lat);
    checks++;
    if (lat !== 12) begin errors++; $display("FAIL latency_b: got %0d want 12", lat); end
    checks++;
    if ({b_cp, b_cc, b_win} !== {3'd4, 3'd0, 1'b0}) begin
      errors++; $display("FAIL illegal_guess_peg: got p=%0d c=%0d w=%b want p=4 c=0 w=0",
                         b_cp, b_cc, b_win);
    end
    guess_b(code(1, 2, 3, 4, 5), lat);
    checks++;
    if ({b_cp, b_win} !== {3'd5, 1'b1}) begin
      errors++; $display("FAIL old_secret_kept: got p=%0d w=%b want p=5 w=1", b_cp, b_win);
    end
  endtask

  task automatic test_turn_limit();
    int lat;
    load_b(code(1, 2, 3, 4, 5));
    checks++;
    if ({b_turn, b_go, b_gr} !== 4'b0001) begin
      errors++; $display("FAIL turn_cleared: got %b want 0001", {b_turn, b_go, b_gr});
    end
    guess_b(code(0, 0, 0, 0, 0), lat);
    checks++;
    if ({b_cp, b_cc} !== 6'd0) begin
      errors++; $display("FAIL score_00: got p=%0d c=%0d want 0 0", b_cp, b_cc);
    end
    guess_b(code(0, 0, 0, 0, 0), lat);
    tick();
    checks++;
    if (b_turn !== (TurnLimit ? 2'd2 : 2'd0)) begin
      errors++; $display("FAIL turn_after_two: got %0d want %0d", b_turn, TurnLimit ? 2 : 0);
    end
    checks++;
    if ({b_go, b_gr} !== (TurnLimit ? 2'b10 : 2'b01)) begin
      errors++; $display("FAIL lost_state: got %b want %b", {b_go, b_gr}, TurnLimit ? 2'b10 : 2'b01);
    end
    load_b(code(1, 2, 3, 4, 5));
    guess_b(code(0, 0, 0, 0, 0), lat);
    guess_b(code(1, 2, 3, 4, 5), lat);
    tick();
    checks++;
    if ({b_win, b_go, b_gr} !== 3'b100) begin
      errors++; $display("FAIL final_turn_win: got %b want 100", {b_win, b_go, b_gr});
    end
    checks++;
    if (b_turn !== (TurnLimit ? 2'd2 : 2'd0)) begin
      errors++; $display("FAIL turn_on_win: got %0d want %0d", b_turn, TurnLimit ? 2 : 0);
    end
  endtask

  task automatic test_reset_mid();
    load_a(code(3, 1, 4, 1, 5));
    a_gin = code(1, 3, 4, 5, 7); a_gv = 1'b1; tick(); a_gv = 1'b0;
    repeat (3) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    checks++;
    if ({a_gr, a_busy, a_win, a_cp, a_cc} !== 9'd0) begin
      errors++; $display("FAIL reset_mid_scan: got %b want 0", {a_gr, a_busy, a_win, a_cp, a_cc});
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_win();
    test_abort();
    test_back_to_back();
    test_secret_err();
    test_turn_limit();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
